// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM state, pipeline record and byte-enable helper for dmem_byte_pipe
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  typedef struct packed {
    logic        v;
    logic        wr;
    logic        err;
    logic        uns;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] word;
  } pipe_t;
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_BYTE ? 4'b0001 << off :
           sz == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
           sz == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed byte/half of a word and sign- or zero-extends it
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_b = i_word[{i_off, 3'b000} +: 8];
  assign w_h = i_off[1] ? i_word[31:16] : i_word[15:0];
  always_comb
    o_data = i_size == SZ_BYTE ? {{24{~i_unsigned & w_b[7]}}, w_b} :
             i_size == SZ_HALF ? {{16{~i_unsigned & w_h[15]}}, w_h} : i_word;
endmodule

// File: rtl/dmem_byte_pipe.sv
// dmem_byte_pipe: byte-addressable data memory with valid/ready requests, configurable read latency and post-reset clear.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of masking the low address bits.
module dmem_byte_pipe
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 256,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);
  localparam int IW = $clog2(DEPTH_WORDS);
  logic [31:0] r_mem [DEPTH_WORDS];
  state_e      r_state;
  logic [IW-1:0] r_cnt;
  logic        r_ready;
  pipe_t       r_pipe [READ_LATENCY];
  logic        w_acc, w_oor, w_mis, w_err;
  logic [1:0]  w_off;
  logic [IW-1:0] w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld;
  pipe_t       w_s0, w_out;
  assign w_acc = req_valid && r_ready;
  assign w_oor = (req_addr >> (IW + 2)) != '0;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign w_off = req_addr[1:0];
`else
  assign w_mis = 1'b0;
  assign w_off = req_size == SZ_HALF ? {req_addr[1], 1'b0} : req_size == SZ_WORD ? 2'b00 : req_addr[1:0];
`endif
  assign w_err = w_oor | (req_size == SZ_BAD) | w_mis;
  assign w_idx = req_addr[IW+1:2];
  assign w_be = byte_en(req_size, w_off);
  assign w_wdata = req_size == SZ_BYTE ? {4{req_wdata[7:0]}} : req_size == SZ_HALF ? {2{req_wdata[15:0]}} : req_wdata;
  // Array is never reset; CLEAR zeroes it one word per cycle when enabled
  always_ff @(posedge clk)
    if (!rst && r_state == ST_CLEAR)
      r_mem[r_cnt] <= '0;
    else if (!rst && w_acc && req_write && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_RUN;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == IW'(DEPTH_WORDS - 1)) begin
        r_state <= ST_RUN;
        r_ready <= 1'b1;
      end
    end else
      r_ready <= 1'b1;
  always_comb begin
    w_s0      = '0;
    w_s0.v    = w_acc;
    w_s0.wr   = req_write;
    w_s0.err  = w_err;
    w_s0.uns  = req_unsigned;
    w_s0.sz   = req_size;
    w_s0.off  = w_off;
    w_s0.word = (w_acc && !req_write && !w_err) ? r_mem[w_idx] : '0;
  end
  // Stage 0 captures the word at acceptance; later stages only delay it
  always_ff @(posedge clk)
    if (rst)
      for (int k = 0; k < READ_LATENCY; k++) r_pipe[k] <= '0;
    else begin
      r_pipe[0] <= w_s0;
      for (int k = 1; k < READ_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
    end
  assign w_out = r_pipe[READ_LATENCY-1];
  dmem_load_align u_align (
    .i_word    (w_out.word),
    .i_size    (w_out.sz),
    .i_off     (w_out.off),
    .i_unsigned(w_out.uns),
    .o_data    (w_ld)
  );
  assign req_ready  = r_ready;
  assign resp_valid = w_out.v;
  assign resp_error = w_out.v & w_out.err;
  assign resp_rdata = (w_out.v && !w_out.wr && !w_out.err) ? w_ld : '0;
endmodule

// File: tb/tb_dmem_byte_pipe.sv
// tb_dmem_byte_pipe: directed self-checking bench for dmem_byte_pipe (READ_LATENCY=3, CLEAR_ON_RESET=1, 256 words)
module tb_dmem_byte_pipe;
  localparam int RL = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [31:0] W20 = 32'h11EE3344;
  localparam logic        MIS_ERR = 1'b1;
`else
  localparam logic [31:0] W20 = 32'hCAFEF00D;
  localparam logic        MIS_ERR = 1'b0;
`endif
  logic        clk = 0, rst = 1, req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  dmem_byte_pipe #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(RL), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
  endtask
  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    check({tag, ".rdy"}, 32'(req_ready), 32'd1);
    drive(w, sz, u, a, d);
    for (int c = 1; c <= RL; c++) begin
      @(negedge clk);
      req_valid = 0;
      if (c == RL) begin
        check({tag, ".v"}, 32'(resp_valid), 32'd1);
        check({tag, ".rd"}, resp_rdata, exp_rd);
        check({tag, ".err"}, 32'(resp_error), 32'(exp_err));
      end else if (c == RL - 1)
        check({tag, ".early"}, 32'(resp_valid), 32'd0);
    end
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!req_ready && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask
  logic [31:0] b2b_addr [4] = '{32'h10, 32'h20, 32'h13, 32'h10};
  logic [1:0]  b2b_sz   [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
  logic        b2b_u    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] b2b_exp  [4] = '{32'h8899AABB, W20, 32'h00000088, 32'hFFFFAABB};
  int cnt, nv;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.error", 32'(resp_error), 32'd0);
    @(negedge clk) rst = 0;
    wait_ready(cnt);
    check("clear_len", cnt, 256);
    xfer("lw_top", 0, 2'b10, 0, 32'h3FC, 0, 32'h0, 0);
    xfer("sw_10", 1, 2'b10, 0, 32'h10, 32'h8899AABB, 32'h0, 0);
    xfer("lb_11", 0, 2'b00, 0, 32'h11, 0, 32'hFFFFFFAA, 0);
    xfer("lbu_11", 0, 2'b00, 1, 32'h11, 0, 32'h000000AA, 0);
    xfer("lh_12", 0, 2'b01, 0, 32'h12, 0, 32'hFFFF8899, 0);
    xfer("lhu_12", 0, 2'b01, 1, 32'h12, 0, 32'h00008899, 0);
    xfer("sw_20", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0);
    xfer("sb_22", 1, 2'b00, 0, 32'h22, 32'h000000EE, 32'h0, 0);
    xfer("lw_20", 0, 2'b10, 0, 32'h20, 0, 32'h11EE3344, 0);
    xfer("sw_21", 1, 2'b10, 0, 32'h21, 32'hCAFEF00D, 32'h0, MIS_ERR);
    xfer("lw_20b", 0, 2'b10, 0, 32'h20, 0, W20, 0);
    // four loads on consecutive cycles; responses expected on negedges 3..6
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= RL && c < RL + 4) begin
        check($sformatf("b2b%0d.v", c - RL), 32'(resp_valid), 32'd1);
        check($sformatf("b2b%0d.rd", c - RL), resp_rdata, b2b_exp[c-RL]);
      end else
        check($sformatf("b2b_idle%0d", c), 32'(resp_valid), 32'd0);
      if (c < 4) drive(0, b2b_sz[c], b2b_u[c], b2b_addr[c], 0);
      else req_valid = 0;
    end
    xfer("lw_oor", 0, 2'b10, 0, 32'h400, 0, 32'h0, 1);
    xfer("sw_oor", 1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 32'h0, 1);
    xfer("lw_0", 0, 2'b10, 0, 32'h0, 0, 32'h0, 0);
    xfer("ld_bad", 0, 2'b11, 0, 32'h10, 0, 32'h0, 1);
    @(negedge clk) drive(0, 2'b10, 0, 32'h10, 0);
    @(negedge clk) drive(0, 2'b10, 0, 32'h20, 0);
    @(negedge clk) begin req_valid = 0; rst = 1; end
    nv = 0;
    repeat (2) begin
      @(negedge clk);
      nv += int'(resp_valid);
    end
    rst = 0;
    cnt = 0;
    while (!req_ready && cnt < 1000) begin
      @(negedge clk);
      nv += int'(resp_valid);
      cnt++;
    end
    check("flush_valid", nv, 0);
    check("reclear_len", cnt, 256);
    xfer("lw_10_clr", 0, 2'b10, 0, 32'h10, 0, 32'h0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
